// File: rtl/smc_wr_strobe_gen_lite18_pkg.sv
// Shared definitions for the lite SMC write-strobe generator.
//   smc_state_e : write sequencer phases
//   LANES       : byte lanes on the lite SMC data bus
//   WE_IDLE     : all byte-lane enables inactive (active-low bus)
package smc_lite_pkg18;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } smc_state_e;

    localparam int LANES = 4;
    localparam logic [LANES-1:0] WE_IDLE = 4'hF;

endpackage

// File: rtl/smc_wr_strobe_gen_lite18_if.sv
// Request/strobe bundle between the write path master and the strobe generator.
//   master : drives wr_req18/wr_be18/wr_setup18/wr_pulse18/wr_hold18/wr_abort18,
//            observes ack/done/busy and the raw strobes
//   slave  : the strobe generator side
interface smc_wr_strobe_gen_lite18_if
    import smc_lite_pkg18::*;
#(
    parameter int CNT_W = 4,
    parameter int LW    = LANES
);
    logic             wr_req18;
    logic [LW-1:0]    wr_be18;
    logic [CNT_W-1:0] wr_setup18;
    logic [CNT_W-1:0] wr_pulse18;
    logic [CNT_W-1:0] wr_hold18;
    logic             wr_abort18;
    logic             wr_ack18;
    logic             wr_done18;
    logic             busy18;
    logic [LW-1:0]    n_r_we18;
    logic             n_r_wr18;
    logic             r_full18;

    modport master (
        output wr_req18, wr_be18, wr_setup18, wr_pulse18, wr_hold18, wr_abort18,
        input  wr_ack18, wr_done18, busy18, n_r_we18, n_r_wr18, r_full18
    );

    modport slave (
        input  wr_req18, wr_be18, wr_setup18, wr_pulse18, wr_hold18, wr_abort18,
        output wr_ack18, wr_done18, busy18, n_r_we18, n_r_wr18, r_full18
    );

endinterface

// File: rtl/smc_wr_strobe_gen_lite18_phase_cnt.sv
// Loadable down-counter timing one write phase.
//   clk/rst_n : clock, synchronous active-low reset
//   load      : load load_val (phase length - 1) on phase entry
//   dec       : count down one step; saturates at zero
//   zero      : counter is zero, i.e. the current cycle ends the phase
module smc_phase_cnt18 #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (dec && cnt != '0)
            cnt <= cnt - CNT_W'(1);
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/smc_wr_strobe_gen_lite18.sv
// Write-strobe timing generator for the lite SMC write path.
// Sequences SETUP -> STROBE -> HOLD from cycle counts latched at accept and
// drives the raw byte-lane enables, write strobe and full-cycle qualifier.
//   sys_clk18     : system clock
//   n_sys_reset18 : synchronous active-low reset
//   bus (slave)   : request fields in; ack/done/busy pulses and raw strobes out
// All outputs are registered from the next-state decode, so they line up
// with the state they describe and nothing is combinational from inputs.
module smc_wr_strobe_gen_lite18
    import smc_lite_pkg18::*;
#(
    parameter int CNT_W = 4,
    parameter int LW    = LANES
) (
    input logic                        sys_clk18,
    input logic                        n_sys_reset18,
    smc_wr_strobe_gen_lite18_if.slave  bus
);

    localparam logic [1:0] S_IDLE   = IDLE;
    localparam logic [1:0] S_SETUP  = SETUP;
    localparam logic [1:0] S_STROBE = STROBE;
    localparam logic [1:0] S_HOLD   = HOLD;

    logic [1:0]       state_q, state_d;
    logic [LW-1:0]    be_q, be_d;
    logic [CNT_W-1:0] pulse_q, hold_q;
    logic             accept;
    logic             cnt_load, cnt_dec, cnt_zero;
    logic [CNT_W-1:0] cnt_val;

    // Strobe length is max(pulse,1); counter holds length-1.
    function automatic logic [CNT_W-1:0] strobe_load(input logic [CNT_W-1:0] p);
        return (p == '0) ? '0 : p - CNT_W'(1);
    endfunction

    smc_phase_cnt18 #(.CNT_W(CNT_W)) u_cnt (
        .clk      (sys_clk18),
        .rst_n    (n_sys_reset18),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (cnt_val),
        .zero     (cnt_zero)
    );

    // Setup length is consumed straight from the request at accept (it goes
    // into the counter), so only be/pulse/hold need holding registers.
    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        cnt_val  = '0;
        case (state_q)
            S_IDLE: begin
                if (bus.wr_req18) begin
                    accept   = 1'b1;
                    cnt_load = 1'b1;
                    if (bus.wr_setup18 != '0) begin
                        state_d = S_SETUP;
                        cnt_val = bus.wr_setup18 - CNT_W'(1);
                    end else begin
                        state_d = S_STROBE;
                        cnt_val = strobe_load(bus.wr_pulse18);
                    end
                end
            end
            S_SETUP: begin
                if (bus.wr_abort18) begin
                    state_d = S_IDLE;
                end else if (cnt_zero) begin
                    state_d  = S_STROBE;
                    cnt_load = 1'b1;
                    cnt_val  = strobe_load(pulse_q);
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            S_STROBE: begin
                // Abort only shortens the strobe; hold is still honoured.
                if (bus.wr_abort18 || cnt_zero) begin
                    if (hold_q != '0) begin
                        state_d  = S_HOLD;
                        cnt_load = 1'b1;
                        cnt_val  = hold_q - CNT_W'(1);
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            S_HOLD: begin
                if (cnt_zero)
                    state_d = S_IDLE;
                else
                    cnt_dec = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign be_d = accept ? bus.wr_be18 : be_q;

    always_ff @(posedge sys_clk18) begin
        if (!n_sys_reset18) begin
            state_q       <= S_IDLE;
            be_q          <= '0;
            pulse_q       <= '0;
            hold_q        <= '0;
            bus.wr_ack18  <= 1'b0;
            bus.wr_done18 <= 1'b0;
            bus.busy18    <= 1'b0;
            bus.n_r_we18  <= WE_IDLE;
            bus.n_r_wr18  <= 1'b1;
            bus.r_full18  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                be_q    <= bus.wr_be18;
                pulse_q <= bus.wr_pulse18;
                hold_q  <= bus.wr_hold18;
            end
            bus.wr_ack18  <= accept;
            // Done only for accesses that reached the strobe.
            bus.wr_done18 <= (state_q == S_STROBE || state_q == S_HOLD) &&
                             (state_d == S_IDLE);
            bus.busy18    <= (state_d != S_IDLE);
            bus.n_r_we18  <= (state_d == S_IDLE) ? WE_IDLE : ~be_d;
            bus.n_r_wr18  <= (state_d != S_STROBE);
            bus.r_full18  <= (state_d == S_STROBE);
        end
    end

endmodule

// File: doc/smc_wr_strobe_gen_lite18.md
Name: smc_wr_strobe_gen_lite18

Overview:
Write-strobe timing generator for the lite SMC write path. It accepts one write access per request and sequences SETUP, STROBE and HOLD phases from programmable cycle counts. It drives the raw byte-lane enables (n_r_we18), the write strobe (n_r_wr18) and the full-cycle qualifier (r_full18). These feed the downstream write-enable gating stage, which ANDs them into the pin-level active-low strobes.

Parameters:
CNT_W, 4, width of each timing field; maximum phase length is 2^CNT_W-1 cycles.
LANES, 4, number of byte lanes; fixed at 4 for the lite SMC.

Ports:
sys_clk18  in  1  system clock; all state changes on its rising edge.
n_sys_reset18  in  1  synchronous, active-low reset.
wr_req18  in  1  write access request; sampled only in IDLE.
wr_be18  in  LANES  byte enables, active high; latched at accept.
wr_setup18  in  CNT_W  setup cycles before the strobe; latched at accept.
wr_pulse18  in  CNT_W  strobe width in cycles; 0 is treated as 1; latched at accept.
wr_hold18  in  CNT_W  hold cycles after the strobe; latched at accept.
wr_abort18  in  1  terminates the current access early.
wr_ack18  out  1  one-cycle pulse: request accepted.
wr_done18  out  1  one-cycle pulse: access completed.
busy18  out  1  high whenever state is not IDLE.
n_r_we18  out  LANES  raw byte-lane write enables, active low.
n_r_wr18  out  1  raw write strobe, active low.
r_full18  out  1  full-cycle strobe qualifier, active high.

Behaviour:
- Reset (n_sys_reset18=0 at a clock edge): state=IDLE; wr_ack18=0, wr_done18=0, busy18=0, n_r_we18=4'hF, n_r_wr18=1, r_full18=0; latched fields cleared. Reset dominates all other inputs, including mid-access; no wr_done18 is produced for an access cut off by reset.
- All outputs are registered; there is no combinational path from inputs to outputs.
- States: IDLE, SETUP, STROBE, HOLD.
- IDLE with wr_req18=1 at an edge:
  - latch be, setup, pulse and hold;
  - next cycle: wr_ack18=1, busy18=1;
  - state becomes SETUP if setup>0, otherwise STROBE.
- SETUP lasts exactly setup cycles, then STROBE.
- STROBE lasts max(pulse,1) cycles, then HOLD if hold>0, otherwise IDLE.
- HOLD lasts exactly hold cycles, then IDLE.
- Total busy18 cycles per access = setup + max(pulse,1) + hold.
- On the first IDLE cycle after STROBE or HOLD: wr_done18=1 for one cycle.
- Output encoding by state:
  - n_r_we18 = ~be_latched in SETUP, STROBE and HOLD; 4'hF in IDLE.
  - n_r_wr18 = 0 only in STROBE.
  - r_full18 = 1 only in STROBE.
  - Net effect downstream: lane pins are low for exactly the STROBE cycles.
- Back-to-back: a wr_req18 high in the wr_done18 cycle is accepted. wr_ack18 then appears on the following cycle, giving a minimum of 1 idle cycle between accesses.
- wr_be18=0: the access still runs; n_r_we18 stays 4'hF and n_r_wr18/r_full18 still pulse.
- Changes to wr_* inputs after accept are ignored until the next accept.
- Abort behaviour:
  - IDLE: ignored.
  - SETUP: next state IDLE; no strobe and no wr_done18.
  - STROBE: next state HOLD with the full latched hold count (IDLE directly if hold=0); wr_done18 is still pulsed on exit.
  - HOLD: ignored; hold timing is always honoured.
- Counter: a single CNT_W down-counter, loaded with (phase length-1) on phase entry; the phase ends when the counter is 0. Counter arithmetic never wraps.

Decomposition:
- Package smc_lite_pkg18 holds:
  - state enum (IDLE=2'd0, SETUP=2'd1, STROBE=2'd2, HOLD=2'd3);
  - LANES constant;
  - all-lanes-inactive constant 4'hF.
- One sub-module, smc_phase_cnt18: a loadable CNT_W down-counter with a zero flag, instantiated once.

Test Plan:
- setup=2, pulse=3, hold=1, be=4'b0101, single req -> ack at T+1; n_r_we18=4'b1010 for 6 cycles; n_r_wr18 low and r_full18 high for exactly 3 cycles (T+3..T+5); done at T+7.
- setup=0, pulse=0, hold=0, be=4'hF -> STROBE lasts 1 cycle; busy18 high 1 cycle; n_r_we18=4'h0 only in that cycle; done on the next cycle.
- Two requests, the second held high during done -> second ack one cycle after done; no overlap of strobes.
- setup=3, abort in 2nd SETUP cycle -> IDLE next cycle; n_r_wr18 never low; no wr_done18.
- pulse=5, hold=2, abort in 2nd STROBE cycle -> strobe lasts 2 cycles; HOLD lasts 2; wr_done18 pulses once.
- n_sys_reset18 low mid-STROBE, with wr_pulse18 changed after accept -> all outputs at reset values next edge; no done; changed inputs do not affect the aborted access.
